ps2_frame_rx: RTL and testbench
===============================

// Module: ps2_frame_rx
// PURPOSE
//  Receives 11-bit PS/2 device frames (start, DATA_W data LSB-first, odd parity, stop).
//  Samples ps2_clk/ps2_data in the system clk domain with synchroniser, glitch filter and
//  inter-edge timeout. Validated bytes enter a FIFO and leave on a valid/ready handshake
//  into the kb decoder. Also reports parity, framing, timeout and overflow errors.
// PARAMETERS
//  DATA_W       8     payload bits per frame
//  FILT_LEN     4     consecutive equal synced samples needed to change filtered ps2_clk (>=2)
//  TIMEOUT_CYC  5000  max clk cycles between falling edges inside a frame (100 us @ 50 MHz)
//  FIFO_DEPTH   4     output FIFO entries, power of 2, >=2
// PORTS
//  clk          in   1                      system clock
//  reset        in   1                      asynchronous, active-high
//  ps2_clk      in   1                      raw device clock, asynchronous
//  ps2_data     in   1                      raw device data, asynchronous
//  out_data     out  DATA_W                 FIFO head byte
//  out_valid    out  1                      FIFO non-empty
//  out_ready    in   1                      consumer accepts head when out_valid&out_ready
//  fifo_count   out  $clog2(FIFO_DEPTH+1)   entries held
//  busy         out  1                      frame in progress (state != IDLE)
//  err_parity   out  1                      1-cycle pulse: parity error, frame dropped
//  err_frame    out  1                      1-cycle pulse: bad start or stop bit
//  err_timeout  out  1                      1-cycle pulse: frame aborted by timeout
//  err_overflow out  1                      1-cycle pulse: good frame dropped, FIFO full
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, filtered clk = 1, sync FFs = 1.
//  Input path: 2-FF sync on both lines. Filtered clk changes only after FILT_LEN equal
//   synced samples. fall = 1-cycle pulse on filtered 1->0. Data sampled from synced
//   ps2_data in the fall cycle.
//  FSM on fall: IDLE: data 0 -> DATA, bit index 0; data 1 -> err_frame, stay IDLE.
//   DATA: shift into shreg[idx], idx++, after DATA_W bits -> PARITY.
//   PARITY: store bit -> STOP.
//   STOP: check, then IDLE. Priority: parity bad -> err_parity; else stop 0 -> err_frame;
//   else FIFO full -> err_overflow; else push. Exactly one outcome per frame.
//  Odd parity: XOR(data bits, parity bit) must be 1.
//  Timeout: counter clears on every fall and in IDLE. Counts while not IDLE.
//   Reaching TIMEOUT_CYC-1 -> IDLE, err_timeout, partial frame discarded.
//  Latency: stop-bit fall at cycle T -> push at edge T+1. out_valid/fifo_count update at T+1.
//  FIFO: registered pointers with wrap at FIFO_DEPTH. out_data = head, stable while
//   out_valid & !out_ready. Pop on out_valid&out_ready. Push+pop same cycle: count
//   unchanged, both performed (also when full). Pop when empty ignored.
//   Overflow never corrupts stored entries.
//  Reset mid-frame or mid-handshake: immediate return to reset state, no error pulse.
// TESTING
//  1. Frame 0x1C (parity 0, stop 1), out_ready=1 -> out_data=0x1C, out_valid 1 cycle, no errs.
//  2. Frame 0xF0 with parity 0 -> err_parity pulse, fifo_count stays 0.
//  3. out_ready=0, send 5 good frames (DEPTH 4) -> count=4, 5th gives err_overflow;
//     pops return bytes 1..4 in order.
//  4. Stop clocking after 4 data bits, wait TIMEOUT_CYC -> err_timeout, busy=0;
//     then 0x29 is received cleanly.
//  5. 2-cycle glitches on ps2_clk (FILT_LEN=4) during frame 0x5A -> 0x5A received, no errs.
//  6. Full FIFO: push and pop same cycle -> count stays 4, order kept.
//     Also assert reset mid-frame -> all outputs 0, next frame OK.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: receives 11-bit PS/2 device frames (start, DATA_W data bits LSB-first,
// odd parity, stop) sampled in the clk domain, and queues validated bytes in a small FIFO.
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   ps2_clk, ps2_data raw asynchronous PS/2 lines
//   out_data          FIFO head byte
//   out_valid         FIFO non-empty
//   out_ready         consumer accepts head when out_valid & out_ready
//   fifo_count        entries held
//   busy              frame in progress
//   err_parity        1-cycle pulse: parity error, frame dropped
//   err_frame         1-cycle pulse: bad start or stop bit
//   err_timeout       1-cycle pulse: frame aborted by inter-edge timeout
//   err_overflow      1-cycle pulse: good frame dropped because FIFO full
module ps2_frame_rx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ps2_clk,
    input  logic                             ps2_data,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             busy,
    output logic                             err_parity,
    output logic                             err_frame,
    output logic                             err_timeout,
    output logic                             err_overflow
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned FLT_W = $clog2(FILT_LEN);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic              filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [FLT_W-1:0]  flt_cnt_q, flt_cnt_d;
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d, busy_q, busy_d;
    logic              err_parity_q, err_parity_d, err_frame_q, err_frame_d;
    logic              err_timeout_q, err_timeout_d, err_overflow_q, err_overflow_d;
    logic              fall_c, pop_c, full_c, push_c;

    // Falling edge of the filtered clock; data is sampled in this cycle.
    assign fall_c = filt_prev_q & ~filt_q;
    assign pop_c  = (count_q != '0) && out_ready;
    assign full_c = (count_q == CNT_W'(FIFO_DEPTH));

    // Synchroniser and glitch filter: the filtered clock follows the synced line only
    // after FILT_LEN consecutive samples disagree with it.
    always_comb begin
        clk_s1_d    = ps2_clk;
        clk_s2_d    = clk_s1_q;
        dat_s1_d    = ps2_data;
        dat_s2_d    = dat_s1_q;
        filt_prev_d = filt_q;
        filt_d      = filt_q;
        flt_cnt_d   = '0;
        if (clk_s2_q != filt_q) begin
            if (flt_cnt_q == FLT_W'(FILT_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end
    end

    // Frame FSM with inter-edge timeout; decides the single outcome of each frame.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shreg_d        = shreg_q;
        par_d          = par_q;
        err_parity_d   = 1'b0;
        err_frame_d    = 1'b0;
        err_timeout_d  = 1'b0;
        err_overflow_d = 1'b0;
        push_c         = 1'b0;
        if (state_q == S_IDLE || fall_c) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (fall_c) begin
                    if (!dat_s2_q) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        err_frame_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (fall_c) begin
                    shreg_d[idx_q] = dat_s2_q;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall_c) begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_c) begin
                    state_d = S_IDLE;
                    if (!((^shreg_q) ^ par_q)) begin
                        err_parity_d = 1'b1;
                    end else if (!dat_s2_q) begin
                        err_frame_d = 1'b1;
                    end else if (full_c && !pop_c) begin
                        err_overflow_d = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !fall_c && to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            state_d       = S_IDLE;
            err_timeout_d = 1'b1;
        end
    end

    // Output FIFO; a push into a full FIFO is only allowed alongside a pop, which
    // frees the slot the write pointer is aimed at.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        out_data_d  = mem_d[rd_ptr_d];
        out_valid_d = (count_d != '0);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q       <= 1'b1;
            clk_s2_q       <= 1'b1;
            dat_s1_q       <= 1'b1;
            dat_s2_q       <= 1'b1;
            filt_q         <= 1'b1;
            filt_prev_q    <= 1'b1;
            flt_cnt_q      <= '0;
            state_q        <= S_IDLE;
            idx_q          <= '0;
            shreg_q        <= '0;
            par_q          <= 1'b0;
            to_cnt_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_parity_q   <= 1'b0;
            err_frame_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            clk_s1_q       <= clk_s1_d;
            clk_s2_q       <= clk_s2_d;
            dat_s1_q       <= dat_s1_d;
            dat_s2_q       <= dat_s2_d;
            filt_q         <= filt_d;
            filt_prev_q    <= filt_prev_d;
            flt_cnt_q      <= flt_cnt_d;
            state_q        <= state_d;
            idx_q          <= idx_d;
            shreg_q        <= shreg_d;
            par_q          <= par_d;
            to_cnt_q       <= to_cnt_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            err_parity_q   <= err_parity_d;
            err_frame_q    <= err_frame_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign fifo_count   = count_q;
    assign busy         = busy_q;
    assign err_parity   = err_parity_q;
    assign err_frame    = err_frame_q;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: drives PS/2 frames bit by bit and compares the
// received bytes and error pulses against an outcome model built from the frame rules.
module tb_ps2_frame_rx;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned FILT_LEN    = 4;
    localparam int unsigned TIMEOUT_CYC = 5000;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int          HALF        = 20;

    logic       clk = 1'b0;
    logic       reset, ps2_clk, ps2_data, out_ready;
    logic [7:0] out_data;
    logic [2:0] fifo_count;
    logic       out_valid, busy, err_parity, err_frame, err_timeout, err_overflow;

    int passed = 0;
    int total  = 0;
    int n_par, n_frm, n_to, n_ovf, n_valid, min_count;
    int lat_cal = 0;
    logic [7:0] got_q [$];

    ps2_frame_rx #(
        .DATA_W(DATA_W), .FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .busy(busy), .err_parity(err_parity),
        .err_frame(err_frame), .err_timeout(err_timeout), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Monitor: counts error pulses and valid cycles, captures every accepted byte.
    always @(negedge clk) begin
        if (err_parity)   n_par++;
        if (err_frame)    n_frm++;
        if (err_timeout)  n_to++;
        if (err_overflow) n_ovf++;
        if (out_valid)    n_valid++;
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (int'(fifo_count) < min_count) min_count = int'(fifo_count);
    end

    task automatic clear_mon();
        n_par = 0; n_frm = 0; n_to = 0; n_ovf = 0; n_valid = 0; min_count = 99;
        got_q.delete();
    endtask

    task automatic idle(input int n);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while the clock is high, then a low half. Optional 2-cycle
    // glitches on the clock, an optional 1-cycle out_ready pulse, and the low-half cycle
    // at which busy was first seen low.
    task automatic drive_bit(input logic b, input bit glitch, input int ready_at, output int lat);
        lat      = -1;
        ps2_data = b;
        for (int c = 1; c <= HALF; c++) begin
            @(posedge clk); #1;
            if (glitch && c == 12) ps2_clk = 1'b0;
            if (glitch && c == 14) ps2_clk = 1'b1;
        end
        ps2_clk = 1'b0;
        for (int c = 1; c <= HALF; c++) begin
            @(posedge clk); #1;
            if (c == ready_at) out_ready = 1'b1;
            else if (ready_at > 0 && c == ready_at + 1) out_ready = 1'b0;
            if (lat < 0 && !busy) lat = c;
            if (glitch && c == 12) ps2_clk = 1'b1;
            if (glitch && c == 14) ps2_clk = 1'b0;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                              input bit glitch, input int ready_at, output int lat);
        logic [10:0] bits;
        int l;
        bits = {stop, (~^d) ^ bad_par, d, 1'b0};
        lat  = -1;
        for (int i = 0; i < 11; i++) begin
            drive_bit(bits[i], glitch, (i == 10) ? ready_at : 0, l);
            if (i == 10) lat = l;
        end
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({out_data, out_valid, fifo_count, busy} !== 13'd0)
            $display("FAIL reset_outputs: got data=%h valid=%b count=%0d busy=%b exp all 0", out_data, out_valid, fifo_count, busy);
        else passed++;
        total++; if ({err_parity, err_frame, err_timeout, err_overflow} !== 4'd0)
            $display("FAIL reset_errs: got %b exp 0000", {err_parity, err_frame, err_timeout, err_overflow});
        else passed++;
        reset = 1'b0;
        idle(10);
        total++; if (busy !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL post_reset_idle: got busy=%b count=%0d exp 0/0", busy, fifo_count);
        else passed++;
    endtask

    task automatic test_single();
        clear_mon(); out_ready = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 0, lat_cal);
        idle(10);
        total++; if (got_q.size() !== 1) $display("FAIL single_count: got %0d bytes exp 1", got_q.size()); else passed++;
        total++; if (got_q.size() > 0 && got_q[0] !== 8'h1C) $display("FAIL single_data: got %h exp 1c", got_q[0]);
        else if (got_q.size() > 0) passed++;
        total++; if (n_valid !== 1) $display("FAIL single_valid_cycles: got %0d exp 1", n_valid); else passed++;
        total++; if (n_par + n_frm + n_to + n_ovf !== 0) $display("FAIL single_errs: got %0d pulses exp 0", n_par + n_frm + n_to + n_ovf); else passed++;
    endtask

    task automatic test_parity();
        int l;
        clear_mon();
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 0, l);
        idle(10);
        total++; if (n_par !== 1) $display("FAIL parity_pulse: got %0d exp 1", n_par); else passed++;
        total++; if (fifo_count !== 3'd0 || got_q.size() !== 0)
            $display("FAIL parity_dropped: got count=%0d bytes=%0d exp 0/0", fifo_count, got_q.size());
        else passed++;
    endtask

    task automatic test_overflow();
        int l;
        clear_mon(); out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 0, l);
        idle(5);
        total++; if (fifo_count !== 3'd4) $display("FAIL ovf_count: got %0d exp 4", fifo_count); else passed++;
        total++; if (n_ovf !== 1) $display("FAIL ovf_pulse: got %0d exp 1", n_ovf); else passed++;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h01)
            $display("FAIL ovf_head: got valid=%b data=%h exp 1/01", out_valid, out_data);
        else passed++;
        out_ready = 1'b1;
        idle(10);
        total++; if (got_q.size() !== 4) $display("FAIL ovf_pops: got %0d exp 4", got_q.size()); else passed++;
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            total++; if (got_q[i] !== 8'(i + 1)) $display("FAIL ovf_order: idx %0d got %h exp %h", i, got_q[i], 8'(i + 1)); else passed++;
        end
    endtask

    task automatic test_timeout();
        int l;
        logic [7:0] d;
        clear_mon(); out_ready = 1'b1;
        d = 8'($urandom);
        drive_bit(1'b0, 1'b0, 0, l);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0, 0, l);
        ps2_data = 1'b1;
        repeat (TIMEOUT_CYC - 100) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1 || n_to !== 0) $display("FAIL timeout_early: got busy=%b pulses=%0d exp 1/0", busy, n_to); else passed++;
        repeat (200) @(posedge clk);
        #1;
        total++; if (n_to !== 1) $display("FAIL timeout_pulse: got %0d exp 1", n_to); else passed++;
        total++; if (busy !== 1'b0 || got_q.size() !== 0) $display("FAIL timeout_abort: got busy=%b bytes=%0d exp 0/0", busy, got_q.size()); else passed++;
        send_frame(8'h29, 1'b0, 1'b1, 1'b0, 0, l);
        idle(10);
        total++; if (got_q.size() !== 1 || got_q[0] !== 8'h29) $display("FAIL timeout_recover: got %0d bytes first=%h exp 29", got_q.size(), got_q[0]); else passed++;
    endtask

    task automatic test_glitch();
        int l;
        clear_mon(); out_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 0, l);
        idle(10);
        total++; if (got_q.size() !== 1 || got_q[0] !== 8'h5A) $display("FAIL glitch_data: got %0d bytes first=%h exp 5a", got_q.size(), got_q[0]); else passed++;
        total++; if (n_par + n_frm + n_to + n_ovf !== 0) $display("FAIL glitch_errs: got %0d pulses exp 0", n_par + n_frm + n_to + n_ovf); else passed++;
    endtask

    task automatic test_bad_start();
        int l;
        clear_mon();
        drive_bit(1'b1, 1'b0, 0, l);
        idle(10);
        total++; if (n_frm !== 1 || busy !== 1'b0) $display("FAIL bad_start: got pulses=%0d busy=%b exp 1/0", n_frm, busy); else passed++;
    endtask

    task automatic test_push_pop_full();
        int l;
        logic [7:0] exp_b [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        clear_mon(); out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b0, 1'b1, 1'b0, 0, l);
        total++; if (fifo_count !== 3'd4) $display("FAIL full_fill: got %0d exp 4", fifo_count); else passed++;
        min_count = 99;
        // busy drops on the same edge as the push, so pulse out_ready in the cycle before it
        send_frame(exp_b[4], 1'b0, 1'b1, 1'b0, lat_cal - 1, l);
        total++; if (n_ovf !== 0 || fifo_count !== 3'd4 || min_count !== 4)
            $display("FAIL full_push_pop: got ovf=%0d count=%0d min=%0d exp 0/4/4", n_ovf, fifo_count, min_count);
        else passed++;
        out_ready = 1'b1;
        idle(10);
        total++; if (got_q.size() !== 5) $display("FAIL full_pops: got %0d exp 5", got_q.size()); else passed++;
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            total++; if (got_q[i] !== exp_b[i]) $display("FAIL full_order: idx %0d got %h exp %h", i, got_q[i], exp_b[i]); else passed++;
        end
    endtask

    task automatic test_random();
        int l, kind, e_par, e_frm;
        logic [7:0] b;
        logic stop;
        bit bad;
        logic [7:0] exp_q [$];
        clear_mon(); out_ready = 1'b1; e_par = 0; e_frm = 0;
        for (int n = 0; n < 10; n++) begin
            b    = 8'($urandom);
            kind = int'($urandom_range(0, 3));
            bad  = (kind == 0);
            stop = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind != 1);
            if (bad) e_par++;
            else if (!stop) e_frm++;
            else exp_q.push_back(b);
            send_frame(b, bad, stop, 1'b0, 0, l);
        end
        idle(10);
        total++; if (n_par !== e_par || n_frm !== e_frm) $display("FAIL rand_errs: got par=%0d frm=%0d exp %0d/%0d", n_par, n_frm, e_par, e_frm); else passed++;
        total++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d exp %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_data: idx %0d got %h exp %h", i, got_q[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int l;
        clear_mon(); out_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 1'b0, 0, l);
        drive_bit(1'b0, 1'b0, 0, l);
        drive_bit(1'b1, 1'b0, 0, l);
        drive_bit(1'b0, 1'b0, 0, l);
        total++; if (busy !== 1'b1 || fifo_count !== 3'd1) $display("FAIL mid_pre: got busy=%b count=%0d exp 1/1", busy, fifo_count); else passed++;
        reset = 1'b1;
        #2;
        total++; if ({out_data, out_valid, fifo_count, busy} !== 13'd0)
            $display("FAIL mid_reset_outputs: got data=%h valid=%b count=%0d busy=%b exp all 0", out_data, out_valid, fifo_count, busy);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(10);
        total++; if (n_par + n_frm + n_to + n_ovf !== 0) $display("FAIL mid_no_err: got %0d pulses exp 0", n_par + n_frm + n_to + n_ovf); else passed++;
        out_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0, l);
        idle(10);
        total++; if (got_q.size() !== 1 || got_q[0] !== 8'h3C) $display("FAIL mid_next_frame: got %0d bytes first=%h exp 3c", got_q.size(), got_q[0]); else passed++;
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_parity();
        test_overflow();
        test_timeout();
        test_glitch();
        test_bad_start();
        test_push_pop_full();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
